enemy_path_sched: RTL and testbench

- Shares one registered enemy-path ROM (x/y coordinate pair per address, 1-cycle read latency) among NUM_EN on-screen enemies.
- Once per frame tick, advances a global path pointer. It then sweeps all alive enemies in order, reading each enemy's coordinate at its phase-offset address and latching it into per-enemy position registers.
- Sits between the frame timing (vblank tick) and the enemy draw stages, which consume the latched positions.

---
 rtl/enemy_pkg.sv | 17 +
 rtl/enemy_path_sched_path_addr.sv | 26 ++
 rtl/enemy_path_sched.sv | 121 ++++++++++++
 tb/tb_enemy_path_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// enemy_pkg: shared FSM state type, default widths and helpers for the enemy path scheduler
package enemy_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    localparam int EN_ADDR_W   = 12;
    localparam int EN_COORD_W  = 12;
    localparam int EN_PATH_LEN = 302;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/enemy_path_sched_path_addr.sv
// path_addr_mod: wrapped path address, (ptr + offset) mod PATH_LEN
//   ptr    - global path pointer, always < PATH_LEN
//   offset - per-enemy phase offset, always < PATH_LEN
//   addr   - resulting ROM address
module path_addr_mod
    import enemy_pkg::*;
#(
    parameter int ADDR_W   = EN_ADDR_W,
    parameter int PATH_LEN = EN_PATH_LEN
) (
    input  logic [ADDR_W-1:0] ptr,
    input  logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W:0] LEN = (ADDR_W+1)'(PATH_LEN);

    logic [ADDR_W:0] sum;
    logic [ADDR_W:0] wrapped;

    // both operands are below PATH_LEN, so one conditional subtract is enough
    assign sum     = {1'b0, ptr} + {1'b0, offset};
    assign wrapped = sum - LEN;
    assign addr    = (sum >= LEN) ? wrapped[ADDR_W-1:0] : sum[ADDR_W-1:0];

endmodule

// File: rtl/enemy_path_sched.sv
// enemy_path_sched: per-frame sweep sharing one registered path ROM among NUM_EN enemies
//   pclk/rst          - pixel clock, async active-low reset
//   frame_tick/enable - frame pulse and tick acceptance gate
//   alive             - per-enemy alive mask, sampled in that enemy's ISSUE cycle
//   rom_addr/rom_x/y  - registered ROM address and its data (1-cycle latency)
//   x_pos/y_pos       - latched coordinates, enemy i at [i*COORD_W +: COORD_W]
//   upd_valid/upd_id  - one-cycle update pulse and updated enemy index
//   busy/path_ptr     - sweep in progress, global path pointer
//   overrun           - sticky flag: tick arrived while a sweep was running
module enemy_path_sched
    import enemy_pkg::*;
#(
    parameter int NUM_EN      = 3,
    parameter int PATH_LEN    = EN_PATH_LEN,
    parameter int ADDR_W      = EN_ADDR_W,
    parameter int COORD_W     = EN_COORD_W,
    parameter int OFFSET_STEP = 100,
    parameter int STEP_DIV    = 1,
    localparam int ID_W       = (NUM_EN > 1) ? clog2(NUM_EN) : 1
) (
    input  logic                      pclk,
    input  logic                      rst,
    input  logic                      frame_tick,
    input  logic                      enable,
    input  logic [NUM_EN-1:0]         alive,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [COORD_W-1:0]        rom_x,
    input  logic [COORD_W-1:0]        rom_y,
    output logic [NUM_EN*COORD_W-1:0] x_pos,
    output logic [NUM_EN*COORD_W-1:0] y_pos,
    output logic                      upd_valid,
    output logic [ID_W-1:0]           upd_id,
    output logic                      busy,
    output logic [ADDR_W-1:0]         path_ptr,
    output logic                      overrun
);

    localparam int DIV_W = (STEP_DIV > 1) ? clog2(STEP_DIV) : 1;

    state_t             state, state_n;
    logic [ID_W-1:0]    idx;
    logic [DIV_W-1:0]   div_cnt;
    logic [ADDR_W-1:0]  offset;
    logic [ADDR_W-1:0]  addr;
    logic               accept, issue_rd, capture, step_idx, last;

    assign last   = idx == ID_W'(NUM_EN - 1);
    assign offset = ADDR_W'(int'(idx) * OFFSET_STEP);
    assign busy   = state != IDLE;

    path_addr_mod #(.ADDR_W(ADDR_W), .PATH_LEN(PATH_LEN)) u_path_addr (
        .ptr    (path_ptr),
        .offset (offset),
        .addr   (addr)
    );

    always_ff @(posedge pclk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_n;

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        issue_rd = 1'b0;
        capture  = 1'b0;
        step_idx = 1'b0;
        case (state)
            IDLE: begin
                accept  = frame_tick && enable;
                state_n = accept ? ISSUE : IDLE;
            end
            ISSUE: begin
                // dead enemies are skipped in a single cycle without a ROM read
                issue_rd = alive[idx];
                step_idx = !alive[idx] && !last;
                state_n  = alive[idx] ? WAIT : (last ? IDLE : ISSUE);
            end
            WAIT: state_n = CAPTURE;
            CAPTURE: begin
                capture  = 1'b1;
                step_idx = !last;
                state_n  = last ? IDLE : ISSUE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            div_cnt   <= '0;
            path_ptr  <= '0;
            rom_addr  <= '0;
            x_pos     <= '0;
            y_pos     <= '0;
            upd_valid <= 1'b0;
            upd_id    <= '0;
            overrun   <= 1'b0;
        end else begin
            upd_valid <= capture;
            if (frame_tick && busy) overrun <= 1'b1;
            if (accept) begin
                idx <= '0;
                if (div_cnt == DIV_W'(STEP_DIV - 1)) begin
                    div_cnt  <= '0;
                    path_ptr <= (path_ptr == ADDR_W'(PATH_LEN - 1)) ? '0 : path_ptr + 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
            if (step_idx) idx <= idx + 1'b1;
            if (issue_rd) rom_addr <= addr;
            if (capture) begin
                x_pos[int'(idx)*COORD_W +: COORD_W] <= rom_x;
                y_pos[int'(idx)*COORD_W +: COORD_W] <= rom_y;
                upd_id <= idx;
            end
        end
    end

endmodule

// File: tb/tb_enemy_path_sched.sv
// tb_enemy_path_sched: scoreboard bench for enemy_path_sched (default and STEP_DIV=2 instances)
module tb_enemy_path_sched;

    typedef struct {
        int id;
        int x;
        int y;
    } exp_t;

    logic        pclk = 1'b0;
    logic        rst;
    logic        frame_tick, enable;
    logic [2:0]  alive;
    logic [11:0] rom_addr, rom_x, rom_y;
    logic [35:0] x_pos, y_pos;
    logic        upd_valid;
    logic [1:0]  upd_id;
    logic        busy, overrun;
    logic [11:0] path_ptr;

    logic        frame_tick2, enable2;
    logic [11:0] rom_addr2, rom_x2, rom_y2;
    logic [35:0] x_pos2, y_pos2;
    logic        upd_valid2;
    logic [1:0]  upd_id2;
    logic        busy2, overrun2;
    logic [11:0] path_ptr2;

    int   total = 0;
    int   bad = 0;
    int   upd_seen = 0;
    int   upd2_cnt = 0;
    int   exp_ptr = 0;
    int   mx[3];
    int   my[3];
    exp_t q[$];

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        rom_x  <= rom_addr;
        rom_y  <= rom_addr + 12'd1000;
        rom_x2 <= rom_addr2;
        rom_y2 <= rom_addr2 + 12'd1000;
    end

    enemy_path_sched dut (
        .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .enable(enable), .alive(alive),
        .rom_addr(rom_addr), .rom_x(rom_x), .rom_y(rom_y), .x_pos(x_pos), .y_pos(y_pos),
        .upd_valid(upd_valid), .upd_id(upd_id), .busy(busy), .path_ptr(path_ptr), .overrun(overrun)
    );

    enemy_path_sched #(.STEP_DIV(2)) dut2 (
        .pclk(pclk), .rst(rst), .frame_tick(frame_tick2), .enable(enable2), .alive(3'b111),
        .rom_addr(rom_addr2), .rom_x(rom_x2), .rom_y(rom_y2), .x_pos(x_pos2), .y_pos(y_pos2),
        .upd_valid(upd_valid2), .upd_id(upd_id2), .busy(busy2), .path_ptr(path_ptr2), .overrun(overrun2)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint packv(input int a0, input int a1, input int a2);
        return (longint'(a2) << 24) | (longint'(a1) << 12) | longint'(a0);
    endfunction

    task automatic start_tick(input logic [2:0] m);
        int a;
        alive   = m;
        exp_ptr = (exp_ptr + 1) % 302;
        for (int i = 0; i < 3; i++)
            if (m[i]) begin
                a     = (exp_ptr + i * 100) % 302;
                mx[i] = a;
                my[i] = a + 1000;
                q.push_back('{i, a, a + 1000});
            end
        @(posedge pclk); #1 frame_tick = 1'b1;
        @(posedge pclk); #1 frame_tick = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int exp_n);
        int n;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge pclk); #1;
        end
        chk(nm, n, exp_n);
    endtask

    task automatic check_state();
        chk("path_ptr", path_ptr, exp_ptr);
        chk("x_pos", x_pos, packv(mx[0], mx[1], mx[2]));
        chk("y_pos", y_pos, packv(my[0], my[1], my[2]));
    endtask

    task automatic sweep(input logic [2:0] m);
        int cyc;
        cyc = 0;
        for (int i = 0; i < 3; i++) cyc += m[i] ? 3 : 1;
        start_tick(m);
        wait_idle("busy_cycles", cyc);
        check_state();
    endtask

    task automatic check_all_zero();
        chk("rst_path_ptr", path_ptr, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_x_pos", x_pos, 0);
        chk("rst_y_pos", y_pos, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_upd_id", upd_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
    endtask

    initial begin
        int e2[4];
        int seen0;
        e2 = '{0, 1, 1, 2};
        rst = 1'b0; frame_tick = 1'b0; enable = 1'b1; alive = 3'b111;
        frame_tick2 = 1'b0; enable2 = 1'b1;
        for (int i = 0; i < 3; i++) begin mx[i] = 0; my[i] = 0; end
        fork
            forever begin
                exp_t e;
                @(negedge pclk);
                if (upd_valid2) upd2_cnt++;
                if (upd_valid) begin
                    upd_seen++;
                    if (q.size() == 0) chk("unexpected_upd", upd_valid, 0);
                    else begin
                        e = q.pop_front();
                        chk("upd_id", upd_id, e.id);
                        chk("upd_x", x_pos[e.id*12 +: 12], e.x);
                        chk("upd_y", y_pos[e.id*12 +: 12], e.y);
                    end
                end
            end
        join_none
        repeat (2) @(posedge pclk);
        #1 check_all_zero();
        rst = 1'b1;
        sweep(3'b111);
        sweep(3'b101);
        chk("overrun_clear", overrun, 0);
        enable = 1'b0;
        @(posedge pclk); #1 frame_tick = 1'b1;
        @(posedge pclk); #1 frame_tick = 1'b0;
        chk("dis_busy", busy, 0);
        chk("dis_ptr", path_ptr, exp_ptr);
        chk("dis_overrun", overrun, 0);
        enable = 1'b1;
        while (exp_ptr != 301) sweep(3'b111);
        sweep(3'b111);
        chk("wrap_ptr0", path_ptr, 0);
        while (exp_ptr != 251) sweep(3'b111);
        chk("ptr251_x", x_pos, packv(251, 49, 149));
        start_tick(3'b111);
        repeat (3) begin @(posedge pclk); #1; end
        frame_tick = 1'b1;
        @(posedge pclk); #1 frame_tick = 1'b0;
        wait_idle("ovr_busy_rest", 5);
        check_state();
        chk("overrun_set", overrun, 1);
        start_tick(3'b111);
        repeat (4) begin @(posedge pclk); #1; end
        rst = 1'b0;
        #1 check_all_zero();
        q.delete();
        exp_ptr = 0;
        for (int i = 0; i < 3; i++) begin mx[i] = 0; my[i] = 0; end
        repeat (2) @(posedge pclk);
        #1 rst = 1'b1;
        seen0 = upd_seen;
        repeat (20) @(posedge pclk);
        #1 chk("no_upd_after_rst", upd_seen - seen0, 0);
        sweep(3'b111);
        for (int k = 0; k < 4; k++) begin
            int n;
            @(posedge pclk); #1 frame_tick2 = 1'b1;
            @(posedge pclk); #1 frame_tick2 = 1'b0;
            n = 0;
            while (busy2 && n < 100) begin n++; @(posedge pclk); #1; end
            chk("div2_busy", n, 9);
            chk("div2_ptr", path_ptr2, e2[k]);
        end
        @(posedge pclk); #1;
        chk("div2_sweeps", upd2_cnt, 12);
        chk("div2_x", x_pos2, packv(2, 102, 202));
        enable2 = 1'b0;
        @(posedge pclk); #1 frame_tick2 = 1'b1;
        @(posedge pclk); #1 frame_tick2 = 1'b0;
        chk("div2_dis_busy", busy2, 0);
        repeat (4) @(posedge pclk);
        #1 chk("div2_dis_ptr", path_ptr2, 2);
        chk("div2_dis_sweeps", upd2_cnt, 12);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
